// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types and constants for the ibus/dbus memory arbiter.
package mem_bus_arbiter_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] MSIZE_BYTE = 2'd0;
    localparam logic [1:0] MSIZE_HALF = 2'd1;
    localparam logic [1:0] MSIZE_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
    typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [3:0]            strobe;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// arb_starve_counter: counts dbus wins over a waiting ibus and forces an ibus grant at the limit.
module arb_starve_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_i,
    input  logic i_valid_i,
    input  logic gnt_i_i,
    input  logic gnt_d_i,
    output logic force_i_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign force_i_o = cnt_q == W'(LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (arb_i)
            cnt_d = (!i_valid_i || gnt_i_i) ? '0 :
                    (gnt_d_i && !force_i_o) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory port between ibus and dbus,
// dbus first, with a starvation guard that periodically forces an ibus grant.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req_valid,
    output logic              m_req_write,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [1:0]        m_req_size,
    output logic [3:0]        m_req_strobe,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_req_ready,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_data,
    output logic              busy
);
    arb_state_t state_q, state_d;
    grant_t     grant_q, grant_d;
    mem_req_t   req_q, req_d;
    logic       force_i, idle, gnt_i, gnt_d, accept, resp;

    assign idle   = state_q == IDLE;
    assign gnt_i  = idle && i_valid && (!d_valid || force_i);
    assign gnt_d  = idle && d_valid && !gnt_i;
    assign accept = state_q == REQ && m_req_ready;
    // a response only counts once the request is being or has been accepted
    assign resp   = m_resp_valid && (accept || state_q == WAIT);

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .arb_i     (idle),
        .i_valid_i (i_valid),
        .gnt_i_i   (gnt_i),
        .gnt_d_i   (gnt_d),
        .force_i_o (force_i)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_d   = req_q;
        if (gnt_d) begin
            state_d = REQ;
            grant_d = G_D;
            req_d   = '{write: d_write, addr: MEM_ADDR_W'(d_addr), size: d_size,
                        strobe: d_write ? d_strobe : 4'h0, wdata: MEM_DATA_W'(d_wdata)};
        end else if (gnt_i) begin
            state_d = REQ;
            grant_d = G_I;
            req_d   = '{write: 1'b0, addr: MEM_ADDR_W'(i_addr), size: MSIZE_WORD,
                        strobe: 4'h0, wdata: '0};
        end else if (resp) begin
            state_d = IDLE;
            grant_d = G_NONE;
        end else if (accept) begin
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= G_NONE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            req_q   <= req_d;
        end
    end

    assign m_req_valid  = state_q == REQ;
    assign m_req_write  = req_q.write;
    assign m_req_addr   = ADDR_W'(req_q.addr);
    assign m_req_size   = req_q.size;
    assign m_req_strobe = req_q.strobe;
    assign m_req_wdata  = DATA_W'(req_q.wdata);

    assign i_addr_ok = accept && grant_q == G_I;
    assign d_addr_ok = accept && grant_q == G_D;
    assign i_data_ok = resp && grant_q == G_I;
    assign d_data_ok = resp && grant_q == G_D;
    assign i_data    = i_data_ok ? m_resp_data : '0;
    assign d_rdata   = d_data_ok ? m_resp_data : '0;
    assign busy      = !idle;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized requesters and memory with a scoreboard-checked transaction model.
module tb_mem_bus_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_data;
    logic        d_valid, d_write, d_addr_ok, d_data_ok;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_strobe;
    logic        m_req_valid, m_req_write, m_req_ready, m_resp_valid, busy;
    logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
    logic [1:0]  m_req_size;
    logic [3:0]  m_req_strobe;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
        .m_req_size(m_req_size), .m_req_strobe(m_req_strobe), .m_req_wdata(m_req_wdata),
        .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .busy(busy)
    );

    typedef struct {
        int          cyc;
        bit          is_d;
        logic        w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [3:0]  st;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] data;
    } ev_t;

    req_t  exp_req[$];
    ev_t   exp_aok[$];
    ev_t   exp_dok[$];
    req_t  rm;
    ev_t   em;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    mon_en = 0;
    bit    log_en = 0;
    bit    prev_mv = 0;
    string order = "";

    // requester and memory model state
    bit i_act, d_act, cur_d;
    int i_left, d_left, i_gap, d_gap, max_gap, mphase, wdelay, starve;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_req.size() > 0 && exp_req[0].cyc < cyc) begin
                chk("req_missing", cyc, exp_req[0].cyc);
                rm = exp_req.pop_front();
            end
            while (exp_aok.size() > 0 && exp_aok[0].cyc < cyc) begin
                chk("addr_ok_missing", cyc, exp_aok[0].cyc);
                em = exp_aok.pop_front();
            end
            while (exp_dok.size() > 0 && exp_dok[0].cyc < cyc) begin
                chk("data_ok_missing", cyc, exp_dok[0].cyc);
                em = exp_dok.pop_front();
            end
            if (m_req_valid && !prev_mv) begin
                if (exp_req.size() == 0) chk1("req_unexpected", m_req_valid, 1'b0);
                else begin
                    rm = exp_req.pop_front();
                    chk("req_cycle", cyc, rm.cyc);
                    chk1("req_write", m_req_write, rm.w);
                    chk("req_addr", m_req_addr, rm.a);
                    chk("req_size", 32'(m_req_size), 32'(rm.sz));
                    chk("req_strobe", 32'(m_req_strobe), 32'(rm.st));
                    if (rm.w) chk("req_wdata", m_req_wdata, rm.wd);
                end
            end
            if (i_addr_ok || d_addr_ok) begin
                chk1("addr_ok_both", i_addr_ok && d_addr_ok, 1'b0);
                if (log_en) begin
                    if (d_addr_ok) order = {order, "D"};
                    else order = {order, "I"};
                end
                if (exp_aok.size() == 0) chk1("addr_ok_unexpected", i_addr_ok || d_addr_ok, 1'b0);
                else begin
                    em = exp_aok.pop_front();
                    chk("addr_ok_cycle", cyc, em.cyc);
                    chk1("addr_ok_is_dbus", d_addr_ok, em.is_d);
                    chk1("addr_ok_busy", busy, 1'b1);
                end
            end
            if (i_data_ok || d_data_ok) begin
                chk1("data_ok_both", i_data_ok && d_data_ok, 1'b0);
                if (exp_dok.size() == 0) chk1("data_ok_unexpected", i_data_ok || d_data_ok, 1'b0);
                else begin
                    em = exp_dok.pop_front();
                    chk("data_ok_cycle", cyc, em.cyc);
                    chk1("data_ok_is_dbus", d_data_ok, em.is_d);
                    chk("data_granted", em.is_d ? d_rdata : i_data, em.data);
                    chk("data_other_zero", em.is_d ? i_data : d_rdata, 32'h0);
                end
            end
        end
        prev_mv <= m_req_valid;
    end

    task automatic step();
        req_t r;
        ev_t  e;
        bit   gd;
        @(posedge clk);
        #1;
        cyc++;
        if (!i_act && i_left > 0) begin
            if (i_gap == 0) begin
                i_act  = 1;
                i_left--;
                i_addr = $urandom & ~32'h3;
            end else i_gap--;
        end
        if (!d_act && d_left > 0) begin
            if (d_gap == 0) begin
                d_act    = 1;
                d_left--;
                d_write  = 1'($urandom_range(0, 1));
                d_addr   = $urandom;
                d_size   = 2'($urandom_range(0, 2));
                d_strobe = 4'($urandom);
                d_wdata  = $urandom;
            end else d_gap--;
        end
        i_valid      = i_act;
        d_valid      = d_act;
        m_req_ready  = 0;
        m_resp_valid = 0;
        m_resp_data  = $urandom;
        e.data       = '0;
        if (mphase == 0) begin
            // arbiter is free this cycle: stray memory strobes must be ignored
            m_resp_valid = $urandom_range(0, 3) == 0;
            m_req_ready  = $urandom_range(0, 3) == 0;
            if (i_act || d_act) begin
                gd     = d_act && !(i_act && starve == LIM);
                starve = (!i_act || !gd) ? 0 : (starve < LIM ? starve + 1 : LIM);
                r.cyc  = cyc + 1;
                r.is_d = gd;
                if (gd) begin
                    r.w   = d_write;
                    r.a   = d_addr;
                    r.sz  = d_size;
                    r.st  = d_write ? d_strobe : 4'h0;
                    r.wd  = d_wdata;
                    d_act = 0;
                    d_gap = $urandom_range(0, max_gap);
                end else begin
                    r.w   = 0;
                    r.a   = i_addr;
                    r.sz  = 2'd2;
                    r.st  = 4'h0;
                    r.wd  = '0;
                    i_act = 0;
                    i_gap = $urandom_range(0, max_gap);
                end
                exp_req.push_back(r);
                cur_d  = gd;
                mphase = 1;
            end else starve = 0;
        end else if (mphase == 1) begin
            if ($urandom_range(0, 2) == 0) begin
                m_req_ready = 1;
                e.cyc  = cyc;
                e.is_d = cur_d;
                exp_aok.push_back(e);
                if ($urandom_range(0, 3) == 0) begin
                    m_resp_valid = 1;
                    e.data = m_resp_data;
                    exp_dok.push_back(e);
                    mphase = 0;
                end else begin
                    mphase = 2;
                    wdelay = $urandom_range(0, 3);
                end
            end
        end else begin
            m_req_ready = $urandom_range(0, 1) == 0;
            if (wdelay == 0) begin
                m_resp_valid = 1;
                e.cyc  = cyc;
                e.is_d = cur_d;
                e.data = m_resp_data;
                exp_dok.push_back(e);
                mphase = 0;
            end else wdelay--;
        end
    endtask

    task automatic run(input int ni, input int nd, input int gap);
        int k;
        i_left  = ni;
        d_left  = nd;
        i_gap   = 0;
        d_gap   = 0;
        max_gap = gap;
        k = 0;
        while (k < 5000 && (i_left > 0 || d_left > 0 || i_act || d_act || mphase != 0)) begin
            step();
            k++;
        end
        chk("run_cycle_budget", 32'(k < 5000), 32'd1);
        for (int j = 0; j < 3; j++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        {i_valid, i_addr, d_valid, d_write, d_addr, d_size, d_strobe, d_wdata} = '0;
        {m_req_ready, m_resp_valid, m_resp_data} = '0;
        {i_act, d_act, cur_d} = '0;
        {i_left, d_left, i_gap, d_gap, max_gap, mphase, wdelay, starve} = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk1("reset_m_req_valid", m_req_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk("reset_m_req_addr", m_req_addr, 32'h0);
        chk("reset_m_req_wdata", m_req_wdata, 32'h0);
        chk1("reset_i_addr_ok", i_addr_ok, 1'b0);
        chk1("reset_d_data_ok", d_data_ok, 1'b0);
        mon_en = 1;

        run(60, 60, 3);
        run(30, 0, 2);
        run(0, 30, 2);
        log_en = 1;
        run(2, 8, 0);
        log_en = 0;
        tests++;
        if (order != "DDDDIDDDDI") begin
            fails++;
            $display("FAIL starve_order: got %s expected DDDDIDDDDI", order);
        end
        run(40, 40, 1);
        chk("leftover_req", exp_req.size(), 0);
        chk("leftover_addr_ok", exp_aok.size(), 0);
        chk("leftover_data_ok", exp_dok.size(), 0);
        mon_en = 0;

        // abandon an ibus read in WAIT through reset
        @(posedge clk);
        #1 i_valid = 1; d_valid = 0; i_addr = 32'hBFC00000; m_req_ready = 0; m_resp_valid = 0;
        @(posedge clk);
        #1 i_valid = 0;
        @(negedge clk);
        chk1("rst_req_valid", m_req_valid, 1'b1);
        chk("rst_req_addr", m_req_addr, 32'hBFC00000);
        @(posedge clk);
        #1 m_req_ready = 1;
        @(negedge clk);
        chk1("rst_i_addr_ok", i_addr_ok, 1'b1);
        chk1("rst_d_addr_ok", d_addr_ok, 1'b0);
        @(posedge clk);
        #1 m_req_ready = 0; reset = 1;
        @(negedge clk);
        chk1("rst_wait_busy", busy, 1'b1);
        chk1("rst_wait_req_valid", m_req_valid, 1'b0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk1("rst_after_busy", busy, 1'b0);
        chk("rst_after_m_req_addr", m_req_addr, 32'h0);
        chk1("rst_after_i_data_ok", i_data_ok, 1'b0);
        @(posedge clk);
        #1 m_resp_valid = 1; m_resp_data = 32'h3C08BFC0;
        @(negedge clk);
        chk1("late_resp_i_data_ok", i_data_ok, 1'b0);
        chk1("late_resp_d_data_ok", d_data_ok, 1'b0);
        chk("late_resp_i_data", i_data, 32'h0);
        chk1("late_resp_busy", busy, 1'b0);
        @(posedge clk);
        #1 m_resp_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
